// File: rtl/mem_agent_types_pkg.sv
// Shared types and constants for the memory agent AXI responders.
package mem_agent_types;

  localparam int AXI_MASTER_DATA_WIDTH  = 64;
  localparam int AXI_MASTER_ADDR_WIDTH  = 32;
  localparam int AXI_ID_WIDTH           = 4;
  localparam int AXI_RD_OUTSTANDING_MAX = 16;
  localparam int DEBG_COUNTER_BITS      = 32;

  localparam logic [31:0] AXI_RD_ADDR_BASE = 32'h4000_0000;
  localparam logic [31:0] AXI_RD_ADDR_HIGH = 32'h5000_0000;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // One accepted read burst waiting for service.
  typedef struct packed {
    logic [31:0]             addr;
    logic [7:0]              len;
    logic [AXI_ID_WIDTH-1:0] id;
    logic                    err;
  } ar_entry_t;

  // Producer side of the AR queue.
  typedef struct packed {
    logic      en;
    ar_entry_t data;
  } fifo_wr_if_t;

  // Consumer side of the AR queue: head entry and empty flag.
  typedef struct packed {
    logic      empty;
    ar_entry_t data;
  } fifo_rd_if_t;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_t;

  // True when any byte of the burst falls outside [base, high).
  // The end address is formed in 33 bits so a carry out of bit 31 is kept.
  function automatic logic ar_out_of_window(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [31:0] base,
                                            input logic [31:0] high);
    logic [8:0]  beats;
    logic [32:0] end_addr;
    beats    = {1'b0, len} + 9'd1;
    end_addr = {1'b0, addr} + {21'd0, beats, 3'b000};
    return (addr < base) || (end_addr > {1'b0, high});
  endfunction

  // Address-derived beat pattern the master self-checks against.
  function automatic logic [63:0] rd_pattern(input logic [31:0] addr);
    return {~addr, addr};
  endfunction

endpackage

// File: rtl/mem_agent_sync_fifo.sv
// Synchronous FIFO with show-ahead read; port bundles are type parameters so
// the write-path agent can reuse it with its own entry type.
module mem_agent_sync_fifo
  import mem_agent_types::*;
#(
  parameter int  DEPTH     = AXI_RD_OUTSTANDING_MAX,
  parameter type payload_t = ar_entry_t,
  parameter type wr_if_t   = fifo_wr_if_t,
  parameter type rd_if_t   = fifo_rd_if_t
) (
  input  logic   clk,
  input  logic   rst,
  input  wr_if_t wr,
  output logic   full,
  input  logic   rd_en,
  output rd_if_t rd
);

  localparam int PW = $clog2(DEPTH);

  payload_t       mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           empty;
  logic           push;
  logic           pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr.en && !full;
  assign pop   = rd_en && !empty;

  // Present the head entry combinationally from storage.
  always_comb begin
    rd.empty = empty;
    rd.data  = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so block order never matters.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the zeroed count already marks every slot invalid, and no reset keeps it RAM-mappable.
    if (push) mem[wr_ptr] <= wr.data;
  end

endmodule

// File: rtl/mem_agent_rd_responder.sv
// AXI4 read responder standing in for DDR: queues AR bursts in order and
// returns an address-derived pattern (or SLVERR zeros) on R.
module mem_agent_rd_responder
  import mem_agent_types::*;
#(
  parameter int          DATA_WIDTH  = AXI_MASTER_DATA_WIDTH,
  parameter int          ADDR_WIDTH  = AXI_MASTER_ADDR_WIDTH,
  parameter int          ID_WIDTH    = AXI_ID_WIDTH,
  parameter int          OUTSTANDING = AXI_RD_OUTSTANDING_MAX,
  parameter logic [31:0] ADDR_BASE   = AXI_RD_ADDR_BASE,
  parameter logic [31:0] ADDR_HIGH   = AXI_RD_ADDR_HIGH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ADDR_WIDTH-1:0]        s_araddr,
  input  logic [7:0]                   s_arlen,
  input  logic [ID_WIDTH-1:0]          s_arid,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic [ID_WIDTH-1:0]          s_rid,
  output logic [1:0]                   s_rresp,
  output logic                         s_rlast,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_ar_cnt,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_r_beats,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_err_cnt
);

  localparam int OW = $clog2(OUTSTANDING) + 1;

  logic        ar_hs;
  logic        rd_hs;
  logic        ar_err;
  logic [31:0] ar_addr;

  logic        stg_vld_q;
  ar_entry_t   stg_q;

  fifo_wr_if_t q_wr;
  fifo_rd_if_t q_rd;
  logic        q_full;
  logic        pop;
  logic        burst_done;

  logic [OW-1:0] outst_q;
  logic [OW-1:0] outst_d;

  rd_state_t               state_q,      state_d;
  logic [31:0]             beat_addr_q,  beat_addr_d;
  logic [7:0]              beats_left_q, beats_left_d;
  logic [AXI_ID_WIDTH-1:0] cur_id_q,     cur_id_d;
  logic                    cur_err_q,    cur_err_d;

  assign ar_addr = 32'(s_araddr);
  assign ar_hs   = s_arvalid && s_arready;
  assign rd_hs   = s_rvalid && s_rready;
  assign ar_err  = ar_out_of_window(ar_addr, s_arlen, ADDR_BASE, ADDR_HIGH);

  // Register each accepted AR with its window check before it enters the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
    end else begin
      stg_vld_q <= ar_hs;
      if (ar_hs) stg_q <= '{addr: ar_addr, len: s_arlen,
                            id: AXI_ID_WIDTH'(s_arid), err: ar_err};
    end
  end

  assign q_wr = '{en: stg_vld_q && !q_full, data: stg_q};

  mem_agent_sync_fifo #(
    .DEPTH     (OUTSTANDING),
    .payload_t (ar_entry_t),
    .wr_if_t   (fifo_wr_if_t),
    .rd_if_t   (fifo_rd_if_t)
  ) u_ar_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (q_wr),
    .full  (q_full),
    .rd_en (pop),
    .rd    (q_rd)
  );

  // Next-state logic: pop in IDLE, step beats in BURST, chain bursts without a bubble.
  always_comb begin
    // NOTE: every variable gets its default first so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    beat_addr_d  = beat_addr_q;
    beats_left_d = beats_left_q;
    cur_id_d     = cur_id_q;
    cur_err_d    = cur_err_q;
    pop          = 1'b0;
    burst_done   = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (!q_rd.empty) begin
          pop          = 1'b1;
          beat_addr_d  = q_rd.data.addr;
          beats_left_d = q_rd.data.len;
          cur_id_d     = q_rd.data.id;
          cur_err_d    = q_rd.data.err;
          state_d      = RD_BURST;
        end
      end
      RD_BURST: begin
        if (rd_hs) begin
          if (beats_left_q != 8'd0) begin
            beat_addr_d  = beat_addr_q + 32'd8;
            beats_left_d = beats_left_q - 8'd1;
          end else begin
            burst_done = 1'b1;
            if (!q_rd.empty) begin
              pop          = 1'b1;
              beat_addr_d  = q_rd.data.addr;
              beats_left_d = q_rd.data.len;
              cur_id_d     = q_rd.data.id;
              cur_err_d    = q_rd.data.err;
            end else begin
              state_d = RD_IDLE;
            end
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Outstanding bursts count from acceptance until their last beat completes,
  // so the active burst holds a slot alongside the queued ones.
  assign outst_d = outst_q + OW'(ar_hs) - OW'(burst_done);

  // State, burst tracking and registered R outputs derived from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      beat_addr_q  <= '0;
      beats_left_q <= '0;
      cur_id_q     <= '0;
      cur_err_q    <= 1'b0;
      s_rvalid     <= 1'b0;
      s_rlast      <= 1'b0;
      s_rdata      <= '0;
      s_rid        <= '0;
      s_rresp      <= AXI_RESP_OKAY;
    end else begin
      state_q      <= state_d;
      beat_addr_q  <= beat_addr_d;
      beats_left_q <= beats_left_d;
      cur_id_q     <= cur_id_d;
      cur_err_q    <= cur_err_d;
      s_rvalid     <= (state_d == RD_BURST);
      s_rlast      <= (state_d == RD_BURST) && (beats_left_d == 8'd0);
      s_rdata      <= (state_d == RD_BURST && !cur_err_d) ?
                      DATA_WIDTH'(rd_pattern(beat_addr_d)) : '0;
      s_rid        <= ID_WIDTH'(cur_id_d);
      s_rresp      <= (state_d == RD_BURST && cur_err_d) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

  // Flow control: AR is refused once OUTSTANDING bursts are in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q   <= '0;
      s_arready <= 1'b1;
    end else begin
      outst_q   <= outst_d;
      s_arready <= (outst_d != OW'(OUTSTANDING));
    end
  end

  // Free-running traffic counters, wrapping at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ar_cnt  <= '0;
      dbg_r_beats <= '0;
      dbg_err_cnt <= '0;
    end else begin
      if (ar_hs)           dbg_ar_cnt  <= dbg_ar_cnt + 1'b1;
      if (rd_hs)           dbg_r_beats <= dbg_r_beats + 1'b1;
      if (ar_hs && ar_err) dbg_err_cnt <= dbg_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_agent_rd_responder.sv
// Directed bench for the AXI read responder: latency, queue depth, error
// window, backpressure stability and mid-burst reset.
module tb_mem_agent_rd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [3:0]  s_arid = '0;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [63:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [31:0] dbg_ar_cnt;
  logic [31:0] dbg_r_beats;
  logic [31:0] dbg_err_cnt;

  int tests = 0;
  int fails = 0;

  mem_agent_rd_responder dut (
    .clk         (clk),
    .rst         (rst),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_araddr    (s_araddr),
    .s_arlen     (s_arlen),
    .s_arid      (s_arid),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rdata     (s_rdata),
    .s_rid       (s_rid),
    .s_rresp     (s_rresp),
    .s_rlast     (s_rlast),
    .dbg_ar_cnt  (dbg_ar_cnt),
    .dbg_r_beats (dbg_r_beats),
    .dbg_err_cnt (dbg_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int n = 0;
    s_arvalid = 1'b1;
    s_araddr  = a;
    s_arlen   = l;
    s_arid    = id;
    while (!s_arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", 64'(n < 200), 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
  endtask

  // Called at a negedge with s_rready high; checks one beat and lets it complete.
  task automatic expect_beat(input string tag, input logic [63:0] d, input logic [3:0] id,
                             input logic [1:0] resp, input logic last, input int max_wait);
    int n = 0;
    while (!s_rvalid && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
    chk({tag, "_rdata"},  s_rdata, d);
    chk({tag, "_rid"},    64'(s_rid), 64'(id));
    chk({tag, "_rresp"},  64'(s_rresp), 64'(resp));
    chk({tag, "_rlast"},  64'(s_rlast), 64'(last));
    @(negedge clk);
  endtask

  initial begin
    logic drop_next;
    logic rdy;
    int   k;
    int   cyc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(s_arready), 64'd1);
    chk("rst_rvalid",  64'(s_rvalid), 64'd0);
    chk("rst_rlast",   64'(s_rlast), 64'd0);
    chk("rst_rdata",   s_rdata, 64'd0);
    chk("rst_rid",     64'(s_rid), 64'd0);
    chk("rst_rresp",   64'(s_rresp), 64'd0);
    chk("rst_ar_cnt",  64'(dbg_ar_cnt), 64'd0);
    chk("rst_beats",   64'(dbg_r_beats), 64'd0);
    chk("rst_err_cnt", 64'(dbg_err_cnt), 64'd0);
    rst = 1'b0;

    // Single burst: latency of two edges, then four pattern beats
    @(negedge clk);
    s_rready = 1'b1;
    send_ar(32'h4000_0000, 8'd3, 4'd5);
    chk("lat_edge1", 64'(s_rvalid), 64'd0);
    @(negedge clk);
    chk("lat_edge2", 64'(s_rvalid), 64'd0);
    @(negedge clk);
    expect_beat("single_b0", 64'hBFFF_FFFF_4000_0000, 4'd5, 2'b00, 1'b0, 0);
    expect_beat("single_b1", 64'hBFFF_FFF7_4000_0008, 4'd5, 2'b00, 1'b0, 0);
    expect_beat("single_b2", 64'hBFFF_FFEF_4000_0010, 4'd5, 2'b00, 1'b0, 0);
    expect_beat("single_b3", 64'hBFFF_FFE7_4000_0018, 4'd5, 2'b00, 1'b1, 0);
    chk("single_idle",  64'(s_rvalid), 64'd0);
    chk("single_ar",    64'(dbg_ar_cnt), 64'd1);
    chk("single_beats", 64'(dbg_r_beats), 64'd4);
    chk("single_err",   64'(dbg_err_cnt), 64'd0);

    // Seventeen ARs with R stalled: sixteen accepted, the seventeenth waits
    do_reset();
    s_rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_arready_%0d", i), 64'(s_arready), 64'd1);
      s_arvalid = 1'b1;
      s_araddr  = 32'h4000_0000 + 32'(i) * 32'h100;
      s_arlen   = 8'd1;
      s_arid    = 4'(i);
      @(negedge clk);
    end
    s_araddr = 32'h4000_1000;
    s_arid   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full_arready_%0d", i), 64'(s_arready), 64'd0);
      @(negedge clk);
    end
    chk("full_ar_cnt", 64'(dbg_ar_cnt), 64'd16);
    chk("full_rvalid_held", 64'(s_rvalid), 64'd1);
    chk("full_rdata_held", s_rdata, 64'hBFFF_FFFF_4000_0000);
    s_rready  = 1'b1;
    drop_next = 1'b0;
    for (int b = 0; b < 17; b++) begin
      for (int j = 0; j < 2; j++) begin
        if (drop_next) s_arvalid = 1'b0;
        drop_next = s_arvalid && s_arready;
        chk($sformatf("chain_%0d_%0d_rvalid", b, j), 64'(s_rvalid), 64'd1);
        chk($sformatf("chain_%0d_%0d_rdata", b, j), s_rdata,
            pat(32'h4000_0000 + 32'(b) * 32'h100 + 32'(j) * 32'd8));
        chk($sformatf("chain_%0d_%0d_rid", b, j), 64'(s_rid), 64'(b % 16));
        chk($sformatf("chain_%0d_%0d_rlast", b, j), 64'(s_rlast), 64'(j));
        @(negedge clk);
      end
    end
    chk("chain_idle",     64'(s_rvalid), 64'd0);
    chk("chain_arvalid",  64'(s_arvalid), 64'd0);
    chk("chain_ar_cnt",   64'(dbg_ar_cnt), 64'd17);
    chk("chain_beats",    64'(dbg_r_beats), 64'd34);
    chk("chain_arready",  64'(s_arready), 64'd1);

    // Out-of-window requests complete as SLVERR with zero data
    do_reset();
    s_rready = 1'b1;
    send_ar(32'h4FFF_FFF8, 8'd1, 4'd2);
    send_ar(32'h3FFF_FFF8, 8'd0, 4'd3);
    expect_beat("err_a_b0", 64'd0, 4'd2, 2'b10, 1'b0, 10);
    expect_beat("err_a_b1", 64'd0, 4'd2, 2'b10, 1'b1, 0);
    expect_beat("err_b_b0", 64'd0, 4'd3, 2'b10, 1'b1, 0);
    chk("err_idle",    64'(s_rvalid), 64'd0);
    chk("err_err_cnt", 64'(dbg_err_cnt), 64'd2);
    chk("err_ar_cnt",  64'(dbg_ar_cnt), 64'd2);
    chk("err_beats",   64'(dbg_r_beats), 64'd3);

    // Random backpressure on a 256-beat burst
    do_reset();
    s_rready = 1'b0;
    send_ar(32'h4000_0000, 8'd255, 4'd7);
    k   = 0;
    cyc = 0;
    while (k < 256 && cyc < 3000) begin
      if (s_rvalid) begin
        chk($sformatf("bp_%0d_rdata", k), s_rdata, pat(32'h4000_0000 + 32'(k) * 32'd8));
        chk($sformatf("bp_%0d_rlast", k), 64'(s_rlast), 64'(k == 255));
        chk($sformatf("bp_%0d_rid", k), 64'(s_rid), 64'd7);
      end
      rdy = 1'($urandom_range(0, 1));
      s_rready = rdy;
      if (s_rvalid && rdy) k++;
      @(negedge clk);
      cyc++;
    end
    chk("bp_beat_count", 64'(k), 64'd256);
    s_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_no_extra_%0d", i), 64'(s_rvalid), 64'd0);
      @(negedge clk);
    end
    chk("bp_r_beats", 64'(dbg_r_beats), 64'd256);

    // Reset during beat 2 of a len-7 burst with three more queued
    do_reset();
    s_rready = 1'b0;
    send_ar(32'h4000_1000, 8'd7, 4'd9);
    send_ar(32'h4000_2000, 8'd0, 4'd1);
    send_ar(32'h4000_2100, 8'd0, 4'd2);
    send_ar(32'h4000_2200, 8'd0, 4'd3);
    s_rready = 1'b1;
    expect_beat("mid_b0", pat(32'h4000_1000), 4'd9, 2'b00, 1'b0, 10);
    expect_beat("mid_b1", pat(32'h4000_1008), 4'd9, 2'b00, 1'b0, 0);
    chk("mid_b2_rdata", s_rdata, pat(32'h4000_1010));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid",  64'(s_rvalid), 64'd0);
    chk("mid_rst_rlast",   64'(s_rlast), 64'd0);
    chk("mid_rst_arready", 64'(s_arready), 64'd1);
    chk("mid_rst_ar_cnt",  64'(dbg_ar_cnt), 64'd0);
    chk("mid_rst_beats",   64'(dbg_r_beats), 64'd0);
    chk("mid_rst_err_cnt", 64'(dbg_err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mid_discard_%0d", i), 64'(s_rvalid), 64'd0);
    end
    send_ar(32'h4000_3000, 8'd1, 4'd4);
    expect_beat("post_b0", pat(32'h4000_3000), 4'd4, 2'b00, 1'b0, 10);
    expect_beat("post_b1", pat(32'h4000_3008), 4'd4, 2'b00, 1'b1, 0);
    chk("post_ar_cnt", 64'(dbg_ar_cnt), 64'd1);
    chk("post_beats",  64'(dbg_r_beats), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_agent_rd_responder.md
# mem_agent_rd_responder

AXI4 read-channel responder (slave side) that terminates the memory agent's AXI read master in place of DDR, for standalone bring-up and soak testing of the master on Ultra96. It accepts read bursts on AR, queues up to `AXI_RD_OUTSTANDING_MAX` of them, and returns a deterministic address-derived data pattern on R, so the master can self-check every beat. Requests outside the read window complete with SLVERR, and free-running debug counters expose traffic totals.

## Interface
Parameters:
- `DATA_WIDTH`, default `AXI_MASTER_DATA_WIDTH` (64). R data width; fixed at 64 for this block.
- `ADDR_WIDTH`, default `AXI_MASTER_ADDR_WIDTH` (32). AR address width.
- `ID_WIDTH`, default `AXI_ID_WIDTH` (4). ARID/RID width.
- `OUTSTANDING`, default `AXI_RD_OUTSTANDING_MAX` (16). AR queue depth; must be a power of 2.
- `ADDR_BASE`, default `AXI_RD_ADDR_BASE` (0x4000_0000). Inclusive low bound of the valid window.
- `ADDR_HIGH`, default `AXI_RD_ADDR_HIGH` (0x5000_0000). Exclusive high bound of the valid window.

Ports:
- `clk` in 1 — single clock. One clock; reset is asynchronous and active-high.
- `rst` in 1 — asynchronous, active-high reset.
- `s_arvalid` in 1 / `s_arready` out 1 — AR handshake.
- `s_araddr` in ADDR_WIDTH — burst start address, 8-byte aligned.
- `s_arlen` in 8 — beats minus 1.
- `s_arid` in ID_WIDTH — transaction ID.
- `s_rvalid` out 1 / `s_rready` in 1 — R handshake.
- `s_rdata` out DATA_WIDTH — pattern data.
- `s_rid` out ID_WIDTH — ID of the current burst.
- `s_rresp` out 2 — 2'b00 OKAY or 2'b10 SLVERR.
- `s_rlast` out 1 — final beat of the burst.
- `dbg_ar_cnt` out DEBG_COUNTER_BITS — accepted AR count.
- `dbg_r_beats` out DEBG_COUNTER_BITS — completed R beats.
- `dbg_err_cnt` out DEBG_COUNTER_BITS — accepted ARs flagged SLVERR.

## Operation
- ARSIZE, ARBURST, ARCACHE and ARPROT are not ported. Only INCR bursts with 8-byte beats are supported.
- On an AR handshake (`s_arvalid && s_arready`), push `{addr, len, id, err}` into the AR queue.
  - `err = (addr < ADDR_BASE) || (addr + (len+1)*8 > ADDR_HIGH)`.
  - Evaluate `err` in 33-bit arithmetic so no carry is lost.
- `s_arready = !full`, with `full` taken from the registered occupancy. A push is refused when the queue is full, even if a pop happens in the same cycle.
- FSM, state IDLE:
  - If the queue is not empty, pop it.
  - Load `beat_addr`, `beats_left = len`, `cur_id` and `cur_err`.
  - Assert `s_rvalid` and go to BURST.
- FSM, state BURST:
  - `s_rvalid` stays high.
  - On `s_rvalid && s_rready` with `beats_left != 0`: `beat_addr += 8` (mod 2^32) and `beats_left -= 1`.
  - On a handshake of the last beat: if the queue is not empty, pop and load the next burst in the same cycle and stay in BURST (no bubble). Otherwise deassert `s_rvalid` and go to IDLE.
- Data pattern:
  - `s_rdata = {~beat_addr, beat_addr}` when `cur_err = 0`.
  - `s_rdata = 0` with `s_rresp = 2'b10` when `cur_err = 1`.
  - An error burst still returns exactly `len+1` beats.
- Outputs hold stable while `s_rvalid && !s_rready`.
- `s_rlast = s_rvalid && (beats_left == 0)`.
- Counters increment on their events and wrap modulo 2^DEBG_COUNTER_BITS.
- Bursts complete strictly in acceptance order. There is no ID-based reordering.

## Timing
- Reset values:
  - `s_arready` = 1.
  - `s_rvalid` = 0, `s_rlast` = 0.
  - `s_rdata`, `s_rid`, `s_rresp` = 0.
  - All counters = 0, queue empty, FSM = IDLE.
- Latency: an AR accepted at edge N produces its first R beat valid after edge N+2, provided the FSM is IDLE.
- Throughput: 1 beat per cycle while `s_rready = 1`, including across burst boundaries.
- Reset asserted mid-burst:
  - `s_rvalid` drops asynchronously.
  - The queue and in-flight burst are discarded; no further beats of them are returned.
  - Counters clear.
- All outputs are registered, with no combinational path from `s_rready` or `s_arvalid` to any output.

## Structure
- Add to `mem_agent_types`:
  - `AXI_ID_WIDTH` (4).
  - `AXI_RESP_OKAY` (2'b00) and `AXI_RESP_SLVERR` (2'b10).
  - `typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [AXI_ID_WIDTH-1:0] id; logic err; } ar_entry_t;`
- Sub-module `mem_agent_sync_fifo`:
  - Parameterised by depth and payload type, holding `ar_entry_t`.
  - Write side exposed as `fifo_wr_if_t` and read side as `fifo_rd_if_t`.
  - The same FIFO is reusable by the write-path agent.

## Test plan
- Reset, then one AR (addr 0x4000_0000, len 3, id 5) with `s_rready = 1`.
  - Expect 4 beats with data 0xBFFF_FFFF_4000_0000, …_BFFF_FFF7_4000_0008, …, rid 5, OKAY.
  - Expect rlast on beat 4 and the first rvalid 2 cycles after AR.
- Issue 17 ARs back-to-back with `s_rready = 0`.
  - Expect `s_arready` low after 16 accepts and the 17th stalled.
  - After setting `s_rready = 1`, all 17 complete in order with no inter-burst bubbles.
- AR at 0x4FFF_FFF8 len 1 (crosses ADDR_HIGH), then 0x3FFF_FFF8 len 0.
  - Expect 2 beats + 1 beat, all SLVERR with data 0.
  - Expect `dbg_err_cnt = 2`.
- Random `s_rready` backpressure on a len-255 burst.
  - Expect every beat held stable while stalled, exactly 256 beats, and `dbg_r_beats = 256`.
- Assert `rst` during beat 2 of a len-7 burst with 3 ARs queued.
  - Expect rvalid to fall immediately and all counters to read 0.
  - A new AR after reset returns the correct pattern starting at beat 0.
